dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the MEM-stage load/store interface driven by the EX/MEM pipeline register (MemRead, MemWrite, ALU address, rt write data).
- Accepts one word request at a time and holds the pipeline through `stall` for a programmable latency.
- Completes each request with a one-cycle `rdata_valid` (loads) or a committed write (stores).
- Illegal requests are flagged on `req_err`.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in storage (power of 2, ≥4).
- LATENCY, 2, stall cycles per accepted request (≥1, ≤15).
- ADDR_W, log2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from EX/MEM register.
- mem_write  in  1  store request from EX/MEM register.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- rdata_valid  out  1  one-cycle pulse, load data valid.
- stall  out  1  pipeline hold request (freeze PC, IF/ID, ID/EX, EX/MEM).
- req_err  out  1  one-cycle pulse, illegal request completed without access.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` asynchronous, active-low.
- Reset values:
  - state=IDLE, counter=0.
  - rdata=0, rdata_valid=0, req_err=0.
  - stall=0 while in reset.
  - Storage array not cleared.
- Request condition: `req = mem_read | mem_write`.
- Illegal condition: `illegal = req & (addr[1:0]!=0 | (mem_read & mem_write))`.
- Word index: `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = req (combinational).
  - On an edge with req & illegal: go to DONE, latch err flag.
  - On an edge with req & LATENCY==1: go to DONE.
  - On an edge with req & LATENCY>1: go to BUSY, counter = LATENCY-1.
  - Without req: stay in IDLE.
- BUSY:
  - stall = 1.
  - Counter decrements each edge.
  - When the counter reaches 1 at an edge: go to DONE.
- Transition into DONE (legal request):
  - Store: write wdata into the array.
  - Load: register array[index] into rdata.
- DONE:
  - stall = 0.
  - rdata_valid = 1 if the completed request was a load.
  - req_err = 1 if it was illegal.
  - Next edge returns to IDLE unconditionally. The request still visible during DONE is the completed one and is not re-accepted.
- Total stall cycles per request = LATENCY; for illegal requests = 1. Completion latency = LATENCY+1 cycles from request presentation.
- Inputs must be held stable while stall=1. Changes during BUSY are ignored: addr, wdata and type are latched at acceptance.
- rdata holds its last load value between loads. Stores do not alter rdata.
- Back-to-back requests: at least one IDLE cycle between DONE and the next acceptance.
- Reset mid-operation (BUSY): the request is aborted and no write is committed. Outputs go to reset values immediately.
- No byte or halfword access; such requests are out of scope.

Decomposition:
- Shared package `dmem_pkg`:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - WORD_W=32;
  - localparam helper for LATENCY counter width (4 bits).
- One sub-module, `dmem_array`:
  - synchronous-write, synchronous-read single-port RAM of DEPTH_WORDS×32;
  - ports: clk, we, re, idx, wdata, rdata.
- FSM, counter and request latches live in dmem_responder.

Test Plan:
- Reset then store (LATENCY=2): mem_write=1, addr=0x10, wdata=0xDEADBEEF.
  - Response: stall high 2 cycles, DONE with rdata_valid=0.
  - A following load from 0x10 → rdata=0xDEADBEEF with rdata_valid pulse on its 3rd cycle.
- Load latency sweep, LATENCY=1 and LATENCY=4, load from 0x20 after storing 0x12345678.
  - Response: stall high exactly 1 and 4 cycles respectively; rdata_valid one cycle only.
- Wrap-around (DEPTH_WORDS=256): store 0xA5A5A5A5 to 0x00000404, then load 0x00000004.
  - Response: rdata=0xA5A5A5A5.
- Illegal requests: load from 0x22; then mem_read=mem_write=1 at 0x30 with wdata=0x1.
  - Response per request: stall 1 cycle, req_err pulse, rdata_valid=0.
  - Word 0x30 unchanged, verified by a subsequent load.
- Reset mid-BUSY (LATENCY=4): store 0xCAFEF00D to 0x40 into word 0x40 previously holding 0x11111111; assert rst_n=0 on the 2nd stall cycle.
  - Response: outputs zero immediately.
  - After release, a load from 0x40 returns 0x11111111.
- Input change during BUSY: accept a load from 0x10, then switch addr to 0x20 while stall=1.
  - Response: rdata equals word 0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   WORD_W  : data word width.
//   CNT_W   : width of the stall-latency down-counter (holds LATENCY-1, LATENCY <= 15).
//   state_e : responder FSM states.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM, DEPTH_WORDS x WORD_W, synchronous write and read.
// Ports:
//   clk   : clock
//   we    : write idx with wdata on this edge
//   re    : capture mem[idx] into rdata on this edge (rdata holds otherwise)
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // NOTE: storage and its read register carry no reset so the array maps onto
  // block RAM; the responder masks rdata until the first load after reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata <= mem_q[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Accepts one word
// load/store at a time, stalls the pipeline for LATENCY cycles, then completes
// with a one-cycle rdata_valid (loads), a committed write (stores) or a
// one-cycle req_err (misaligned or simultaneous read+write requests).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_read     : load request
//   mem_write    : store request
//   addr         : byte address; word index is addr[ADDR_W+1:2], upper bits ignored
//   wdata        : store data
//   rdata        : last load data, registered, 0 after reset
//   rdata_valid  : one-cycle pulse when load data is valid
//   stall        : pipeline hold request
//   req_err      : one-cycle pulse for an illegal request (no access made)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int LATENCY     = 2,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              req_err
);

  localparam bit             SINGLE_CYCLE = (LATENCY == 1);
  localparam logic [CNT_W-1:0] BUSY_INIT  = CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              is_read_q;
  logic              rdata_valid_q;
  logic              req_err_q;
  logic              loaded_q;     // a load has completed since reset

  logic              req;
  logic              illegal;
  logic [ADDR_W-1:0] in_idx;
  logic              in_idle;
  logic              commit;
  logic              acc_read;
  logic [ADDR_W-1:0] acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_addr_bits;

  assign req     = mem_read | mem_write;
  assign illegal = req & ((addr[1:0] != 2'b00) | (mem_read & mem_write));
  assign in_idx  = addr[ADDR_W+1:2];
  assign in_idle = (state_q == IDLE);

  // Upper address bits alias onto the array (wrap modulo DEPTH_WORDS*4).
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // The access happens on the edge that enters DONE. With LATENCY==1 that is
  // the acceptance edge itself, so the live inputs are used instead of the
  // latched copies, which are only being captured on that same edge.
  assign commit = (in_idle & req & ~illegal & SINGLE_CYCLE)
                | ((state_q == BUSY) & (cnt_q == CNT_W'(1)));
  assign acc_read  = in_idle ? mem_read : is_read_q;
  assign acc_idx   = in_idle ? in_idx   : idx_q;
  assign acc_wdata = in_idle ? wdata    : wdata_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (commit & ~acc_read),
    .re    (commit &  acc_read),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // stall is combinational in IDLE so the request cycle itself is held;
  // gating with rst_n keeps it low while reset is asserted.
  assign stall       = rst_n & ((in_idle & req) | (state_q == BUSY));
  assign rdata       = loaded_q ? arr_rdata : '0;
  assign rdata_valid = rdata_valid_q;
  assign req_err     = req_err_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      is_read_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      req_err_q     <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q     <= in_idx;
            wdata_q   <= wdata;
            is_read_q <= mem_read;
            if (illegal) begin
              state_q   <= DONE;
              req_err_q <= 1'b1;
            end else if (SINGLE_CYCLE) begin
              state_q       <= DONE;
              rdata_valid_q <= mem_read;
              loaded_q      <= loaded_q | mem_read;
            end else begin
              state_q <= BUSY;
              cnt_q   <= BUSY_INIT;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q       <= DONE;
            rdata_valid_q <= is_read_q;
            loaded_q      <= loaded_q | is_read_q;
          end
        end
        DONE: begin
          // The request still on the inputs is the one just completed.
          state_q       <= IDLE;
          rdata_valid_q <= 1'b0;
          req_err_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Three instances (LATENCY 1, 2, 4)
// share the clock; each has its own inputs and reset. Directed vectors come
// from a table, corner cases from hand-written sequences, and a random phase
// is checked against a word-level memory model.
module tb_dmem_responder;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_n;
  logic [N-1:0] mem_read;
  logic [N-1:0] mem_write;
  logic [31:0]  addr  [N];
  logic [31:0]  wdata [N];
  logic [31:0]  rdata [N];
  logic [N-1:0] rdata_valid;
  logic [N-1:0] stall;
  logic [N-1:0] req_err;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     (g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .mem_read    (mem_read[g]),
      .mem_write   (mem_write[g]),
      .addr        (addr[g]),
      .wdata       (wdata[g]),
      .rdata       (rdata[g]),
      .rdata_valid (rdata_valid[g]),
      .stall       (stall[g]),
      .req_err     (req_err[g])
    );
  end

  int lat_of [N] = '{1, 2, 4};

  // Reference model: word contents, which words are known, last load value.
  logic [31:0] mem_m   [N][256];
  bit          known_m [N][256];
  logic [31:0] last_m  [N];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          inst;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chg;
    logic [31:0] a2;
    int          e_stall;
    bit          e_valid;
    bit          e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs(input int i);
    mem_read[i]  = 1'b0;
    mem_write[i] = 1'b0;
    addr[i]      = 32'h0;
    wdata[i]     = 32'h0;
  endtask

  task automatic add_vec(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit chg, input logic [31:0] a2,
                         input int es, input bit ev, input bit ee, input logic [31:0] er);
    vec_t v;
    v.inst = i; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.chg = chg; v.a2 = a2;
    v.e_stall = es; v.e_valid = ev; v.e_err = ee; v.e_rdata = er;
    vecs.push_back(v);
  endtask

  // One complete request: present, count stall cycles, check DONE, check the
  // following IDLE cycle, then update the model from the request rules.
  task automatic do_req(input vec_t v, input string tag);
    int i;
    int n;
    bit legal;
    int idx;
    i = v.inst;
    @(posedge clk); #1;
    mem_read[i]  = v.rd;
    mem_write[i] = v.wr;
    addr[i]      = v.a;
    wdata[i]     = v.wd;
    #0;
    n = 0;
    while (stall[i] && n < 40) begin
      n++;
      @(posedge clk); #1;
      if (v.chg && stall[i]) begin
        addr[i]  = v.a2;
        wdata[i] = ~v.wd;
      end
    end
    check($sformatf("%s.stall_cycles", tag), n, v.e_stall);
    check($sformatf("%s.rdata_valid", tag), {31'b0, rdata_valid[i]}, {31'b0, v.e_valid});
    check($sformatf("%s.req_err", tag), {31'b0, req_err[i]}, {31'b0, v.e_err});
    check($sformatf("%s.rdata", tag), rdata[i], v.e_rdata);
    idle_inputs(i);
    @(posedge clk); #1;
    check($sformatf("%s.after_valid", tag), {31'b0, rdata_valid[i]}, 32'h0);
    check($sformatf("%s.after_err", tag), {31'b0, req_err[i]}, 32'h0);
    check($sformatf("%s.after_stall", tag), {31'b0, stall[i]}, 32'h0);
    legal = (v.a[1:0] == 2'b00) && !(v.rd && v.wr);
    idx   = int'(v.a[9:2]);
    if (legal && v.wr) begin
      mem_m[i][idx]   = v.wd;
      known_m[i][idx] = 1'b1;
    end
    if (legal && v.rd) last_m[i] = mem_m[i][idx];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < N; i++) begin
      last_m[i] = 32'h0;
      for (int w = 0; w < 256; w++) known_m[i][w] = 1'b0;
    end

    // Reset with requests pending: stall must stay low while in reset.
    rst_n = '0;
    for (int i = 0; i < N; i++) begin
      mem_read[i] = 1'b1; mem_write[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    #12;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset%0d.stall", i), {31'b0, stall[i]}, 32'h0);
      check($sformatf("reset%0d.valid", i), {31'b0, rdata_valid[i]}, 32'h0);
      check($sformatf("reset%0d.err", i), {31'b0, req_err[i]}, 32'h0);
      check($sformatf("reset%0d.rdata", i), rdata[i], 32'h0);
      idle_inputs(i);
    end
    @(negedge clk);
    rst_n = '1;

    //       inst rd wr addr          wdata         chg a2           stall valid err rdata
    add_vec(1,   0, 1, 32'h10,       32'hDEADBEEF, 0, 32'h0,       2,    0,    0,  32'h0);
    add_vec(1,   1, 0, 32'h10,       32'h0,        0, 32'h0,       2,    1,    0,  32'hDEADBEEF);
    add_vec(0,   0, 1, 32'h20,       32'h12345678, 0, 32'h0,       1,    0,    0,  32'h0);
    add_vec(0,   1, 0, 32'h20,       32'h0,        0, 32'h0,       1,    1,    0,  32'h12345678);
    add_vec(2,   0, 1, 32'h20,       32'h12345678, 0, 32'h0,       4,    0,    0,  32'h0);
    add_vec(2,   1, 0, 32'h20,       32'h0,        0, 32'h0,       4,    1,    0,  32'h12345678);
    add_vec(1,   0, 1, 32'h404,      32'hA5A5A5A5, 0, 32'h0,       2,    0,    0,  32'hDEADBEEF);
    add_vec(1,   1, 0, 32'h4,        32'h0,        0, 32'h0,       2,    1,    0,  32'hA5A5A5A5);
    add_vec(1,   0, 1, 32'h30,       32'h00000055, 0, 32'h0,       2,    0,    0,  32'hA5A5A5A5);
    add_vec(1,   1, 0, 32'h22,       32'h0,        0, 32'h0,       1,    0,    1,  32'hA5A5A5A5);
    add_vec(1,   1, 1, 32'h30,       32'h1,        0, 32'h0,       1,    0,    1,  32'hA5A5A5A5);
    add_vec(1,   1, 0, 32'h30,       32'h0,        0, 32'h0,       2,    1,    0,  32'h00000055);
    add_vec(1,   1, 0, 32'h10,       32'h0,        1, 32'h20,      2,    1,    0,  32'hDEADBEEF);
    add_vec(2,   0, 1, 32'h40,       32'h11111111, 0, 32'h0,       4,    0,    0,  32'h12345678);
    add_vec(2,   1, 0, 32'h20,       32'h0,        1, 32'h40,      4,    1,    0,  32'h12345678);
    add_vec(2,   0, 1, 32'h24,       32'h0BADF00D, 1, 32'h40,      4,    0,    0,  32'h12345678);
    add_vec(2,   1, 0, 32'h40,       32'h0,        0, 32'h0,       4,    1,    0,  32'h11111111);
    add_vec(2,   1, 0, 32'h24,       32'h0,        0, 32'h0,       4,    1,    0,  32'h0BADF00D);
    add_vec(0,   0, 1, 32'h3FC,      32'hFFFFFFFF, 0, 32'h0,       1,    0,    0,  32'h12345678);
    add_vec(0,   1, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,       1,    1,    0,  32'hFFFFFFFF);

    for (int k = 0; k < vecs.size(); k++) do_req(vecs[k], $sformatf("vec%0d", k));

    // Reset during BUSY on the LATENCY=4 instance: the store must not commit.
    @(posedge clk); #1;
    mem_read[2] = 1'b0; mem_write[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D;
    #0;
    check("midrst.stall1", {31'b0, stall[2]}, 32'h1);
    @(posedge clk); #1;
    check("midrst.stall2", {31'b0, stall[2]}, 32'h1);
    rst_n[2] = 1'b0;
    #1;
    check("midrst.stall", {31'b0, stall[2]}, 32'h0);
    check("midrst.valid", {31'b0, rdata_valid[2]}, 32'h0);
    check("midrst.err", {31'b0, req_err[2]}, 32'h0);
    check("midrst.rdata", rdata[2], 32'h0);
    idle_inputs(2);
    @(negedge clk);
    rst_n[2] = 1'b1;
    last_m[2] = 32'h0;
    v.inst = 2; v.rd = 1; v.wr = 0; v.a = 32'h40; v.wd = 0; v.chg = 0; v.a2 = 0;
    v.e_stall = 4; v.e_valid = 1; v.e_err = 0; v.e_rdata = 32'h11111111;
    do_req(v, "midrst.reload");

    // Random phase against the model.
    for (int k = 0; k < 150; k++) begin
      int          i;
      int          sel;
      logic [31:0] r;
      logic [7:0]  wi;
      bit          legal;
      i   = $urandom_range(0, N - 1);
      sel = $urandom_range(0, 9);
      r   = $urandom;
      wi  = 8'($urandom_range(0, 255));
      v.inst = i;
      v.a    = {r[21:0], wi, 2'b00};
      v.wd   = $urandom;
      v.chg  = 1'($urandom_range(0, 1));
      v.a2   = $urandom;
      v.rd   = 1'b0;
      v.wr   = 1'b0;
      if (sel == 0) begin
        v.rd = 1'b1;
        v.a[1:0] = 2'($urandom_range(1, 3));
      end else if (sel == 1) begin
        v.rd = 1'b1; v.wr = 1'b1;
      end else if (sel < 6 || !known_m[i][wi]) begin
        v.wr = 1'b1;
      end else begin
        v.rd = 1'b1;
      end
      legal = (v.a[1:0] == 2'b00) && !(v.rd && v.wr);
      if (legal) begin
        v.e_stall = lat_of[i];
        v.e_valid = v.rd;
        v.e_err   = 1'b0;
        v.e_rdata = v.rd ? mem_m[i][wi] : last_m[i];
      end else begin
        v.e_stall = 1;
        v.e_valid = 1'b0;
        v.e_err   = 1'b1;
        v.e_rdata = last_m[i];
      end
      do_req(v, $sformatf("rnd%0d.i%0d", k, i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
